// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - issue/writeback handshake bundle for muldiv_unit
interface muldiv_unit_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;

    modport master (
        output in_valid, op, a, b, flush, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, op, a, b, flush, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative N-bit multiply/divide unit, N+1 cycle latency
// Signed operation (op[2]) is built only when MULDIV_SIGNED_EN is defined.
module muldiv_unit #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t         state, state_nx;
    logic [CW-1:0]  cnt;
    logic [1:0]     op_q;
    logic [N-1:0]   acc;
    logic [N-1:0]   lo;
    logic [N-1:0]   opnd;
    logic [N-1:0]   res_q;
    logic           accept;
    logic [N-1:0]   a_in, b_in;
    logic [N:0]     mul_sum;
    logic [N:0]     div_shift;
    logic [N+1:0]   div_diff;
    logic           div_ok;
    logic [2*N-1:0] prod;
    logic [N-1:0]   quo, rem;
    logic [N-1:0]   fin_res;
`ifdef MULDIV_SIGNED_EN
    logic           sa, sb;
    logic           neg_q, neg_r;
`endif

    assign accept = (state == IDLE) && bus.in_valid && !bus.flush;

    // Iteration runs on magnitudes; signs are reapplied in the final cycle.
    always_comb begin
`ifdef MULDIV_SIGNED_EN
        sa   = bus.op[2] & bus.a[N-1];
        sb   = bus.op[2] & bus.b[N-1];
        a_in = sa ? -bus.a : bus.a;
        b_in = sb ? -bus.b : bus.b;
`else
        a_in = bus.a;
        b_in = bus.b;
`endif
    end

    always_comb begin
        mul_sum   = {1'b0, acc} + (lo[0] ? {1'b0, opnd} : {(N+1){1'b0}});
        div_shift = {acc, lo[N-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, opnd};
        div_ok    = !div_diff[N+1];
    end

    // Final cycle: the counter has reached zero and the raw product/quotient is settled.
    always_comb begin
        prod = {acc, lo};
        quo  = lo;
        rem  = acc;
`ifdef MULDIV_SIGNED_EN
        if (neg_q) prod = -prod;
        if (neg_q && opnd != '0) quo = -quo;
        if (neg_r) rem = -rem;
`endif
        case (op_q)
            2'b00:   fin_res = prod[N-1:0];
            2'b01:   fin_res = prod[2*N-1:N];
            2'b10:   fin_res = quo;
            default: fin_res = rem;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.result    = '0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (accept) state_nx = BUSY;
            end
            BUSY: begin
                if (bus.flush)     state_nx = IDLE;
                else if (cnt == '0) state_nx = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                bus.result    = res_q;
                if (bus.flush || bus.out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            op_q  <= '0;
            acc   <= '0;
            lo    <= '0;
            opnd  <= '0;
            res_q <= '0;
`ifdef MULDIV_SIGNED_EN
            neg_q <= 1'b0;
            neg_r <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_q  <= bus.op[1:0];
                    cnt   <= CW'(N);
                    acc   <= '0;
                    res_q <= '0;
                    if (bus.op[1]) begin
                        lo   <= a_in;
                        opnd <= b_in;
                    end else begin
                        lo   <= b_in;
                        opnd <= a_in;
                    end
`ifdef MULDIV_SIGNED_EN
                    neg_q <= sa ^ sb;
                    neg_r <= sa;
`endif
                end
                BUSY: if (!bus.flush) begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                        if (op_q[1]) begin
                            acc <= div_ok ? div_diff[N-1:0] : div_shift[N-1:0];
                            lo  <= {lo[N-2:0], div_ok};
                        end else begin
                            acc <= mul_sum[N:1];
                            lo  <= {mul_sum[0], lo[N-1:1]};
                        end
                    end else begin
                        res_q <= fin_res;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed vector bench for muldiv_unit
module tb_muldiv_unit;
    localparam int N = 32;

    typedef struct {
        logic [2:0]   op;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] exp;
        string        name;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    muldiv_unit_if #(.N(N)) bus ();

    muldiv_unit #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [2:0] o, input logic [N-1:0] x, input logic [N-1:0] y,
                           input logic [N-1:0] e, input string nm);
        vec_t v;
        v.op = o; v.a = x; v.b = y; v.exp = e; v.name = nm;
        vecs.push_back(v);
    endtask

    task automatic issue(input logic [2:0] o, input logic [N-1:0] x, input logic [N-1:0] y);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op = o;
        bus.a  = x;
        bus.b  = y;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic drain();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        issue(v.op, v.a, v.b);
        wait_done(lat);
        chk({v.name, "_latency"}, 64'(lat), 64'd33);
        chk(v.name, 64'(bus.result), 64'(v.exp));
        drain();
    endtask

    initial begin
        int lat;
        logic [N-1:0] held;

        add_vec(3'b000, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A, "mul_7x6");
        add_vec(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_ones");
        add_vec(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "mul_ones_lo");
        add_vec(3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, "mul_shift_lo");
        add_vec(3'b001, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, "mulhu_shift");
        add_vec(3'b010, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, "divu_by0");
        add_vec(3'b011, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, "remu_by0");
        add_vec(3'b010, 32'd100,       32'd7,         32'd14,        "divu_100_7");
        add_vec(3'b011, 32'd100,       32'd7,         32'd2,         "remu_100_7");
        add_vec(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "divu_big");
        add_vec(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "remu_big");
        add_vec(3'b010, 32'd5,         32'd10,        32'd0,         "divu_small");
        add_vec(3'b011, 32'd5,         32'd10,        32'd5,         "remu_small");
        add_vec(3'b010, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, "divu_by1");
`ifdef MULDIV_SIGNED_EN
        add_vec(3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "mulh_s_m1");
        add_vec(3'b100, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1, "mul_s_m3x5");
        add_vec(3'b101, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, "mulh_s_m3x5");
        add_vec(3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, "div_s_m7_2");
        add_vec(3'b111, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, "rem_s_m7_2");
        add_vec(3'b110, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, "div_s_7_m2");
        add_vec(3'b111, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, "rem_s_7_m2");
        add_vec(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_s_ovf");
        add_vec(3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "rem_s_ovf");
        add_vec(3'b110, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, "div_s_by0");
        add_vec(3'b111, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, "rem_s_by0");
`else
        add_vec(3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulh_op2_ignored");
        add_vec(3'b110, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, "div_op2_ignored");
        add_vec(3'b111, 32'hFFFF_FFF9, 32'd2,         32'h0000_0001, "rem_op2_ignored");
`endif

        reset = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op        = '0;
        bus.a         = '0;
        bus.b         = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
        chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset_result", 64'(bus.result), 64'd0);
        reset = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // result reads zero while busy
        issue(3'b000, 32'd7, 32'd6);
        repeat (3) @(posedge clk);
        #1;
        chk("busy_result_zero", 64'(bus.result), 64'd0);
        chk("busy_in_ready", 64'(bus.in_ready), 64'd0);
        wait_done(lat);
        drain();

        // flush mid-operation
        issue(3'b000, 32'd7, 32'd6);
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        repeat (40) @(posedge clk);
        #1;
        chk("flush_no_result", 64'(bus.out_valid), 64'd0);
        run_vec(vecs[0]);

        // flush beats in_valid in IDLE
        @(negedge clk);
        bus.flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.op = 3'b000; bus.a = 32'd3; bus.b = 32'd3;
        @(posedge clk);
        #1 begin bus.flush = 1'b0; bus.in_valid = 1'b0; end
        chk("flush_wins_in_ready", 64'(bus.in_ready), 64'd1);
        repeat (40) @(posedge clk);
        #1;
        chk("flush_wins_no_result", 64'(bus.out_valid), 64'd0);

        // hold in DONE
        issue(3'b000, 32'd7, 32'd6);
        wait_done(lat);
        held = bus.result;
        chk("hold_first", 64'(held), 64'h2A);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("hold_result", 64'(bus.result), 64'h2A);
            chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
            chk("hold_out_valid", 64'(bus.out_valid), 64'd1);
        end
        // drain cycle also presents a new op: it must not be taken
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.op = 3'b000; bus.a = 32'd2; bus.b = 32'd2;
        @(posedge clk);
        #1 begin bus.out_ready = 1'b0; bus.in_valid = 1'b0; end
        chk("drain_out_valid", 64'(bus.out_valid), 64'd0);
        chk("drain_in_ready", 64'(bus.in_ready), 64'd1);
        chk("drain_result", 64'(bus.result), 64'd0);
        @(posedge clk);
        #1;
        chk("drain_no_accept", 64'(bus.in_ready), 64'd1);

        // flush and out_ready together in DONE
        issue(3'b010, 32'd9, 32'd3);
        wait_done(lat);
        chk("done_flush_result", 64'(bus.result), 64'd3);
        @(negedge clk);
        bus.flush = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 begin bus.flush = 1'b0; bus.out_ready = 1'b0; end
        chk("done_flush_out_valid", 64'(bus.out_valid), 64'd0);
        chk("done_flush_in_ready", 64'(bus.in_ready), 64'd1);

        // asynchronous reset mid-operation
        issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("async_reset_in_ready", 64'(bus.in_ready), 64'd1);
        chk("async_reset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("async_reset_result", 64'(bus.result), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        run_vec(vecs[7]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter N, default 32, is the operand and result width; legal values are 8, 16, 32 and 64.
REQ-002 clk  input  1  is the sole clock; every register updates on its rising edge.
REQ-003 reset  input  1  is an asynchronous, active-high reset.
REQ-004 in_valid  input  1  means the issue stage is presenting an operation.
REQ-005 in_ready  output  1  means the unit can accept an operation this cycle.
REQ-006 op  input  3  selects the operation: bit[1:0] 00=MUL, 01=MULH, 10=DIV, 11=REM; bit[2]=1 selects signed operands.
REQ-007 a, b  input  N each  carry the operands; a is the multiplicand or dividend, b is the multiplier or divisor.
REQ-008 flush  input  1  aborts any in-flight operation.
REQ-009 out_valid  output  1  means result is valid.
REQ-010 out_ready  input  1  means the writeback stage consumes result this cycle.
REQ-011 result  output  N  is the operation result.

Function
REQ-012 The unit SHALL implement a three-state FSM (IDLE, BUSY, DONE); in_ready SHALL equal (state==IDLE), and out_valid SHALL equal (state==DONE).
REQ-013 In IDLE with in_valid=1 and flush=0, the unit SHALL latch op, a and b, go to BUSY, and load the iteration counter with N.
REQ-014 In BUSY, the unit SHALL perform one iteration per cycle: shift-add for MUL/MULH, restoring shift-subtract for DIV/REM; it SHALL decrement the counter and go to DONE when the counter reaches 0.
REQ-015 Latency SHALL be exactly N+1 cycles from the accept edge to out_valid=1, independent of operand values.
REQ-016 The MUL result SHALL be the low N bits of the 2N-bit product; the MULH result SHALL be the high N bits.
REQ-017 The DIV result SHALL be the quotient and the REM result SHALL be the remainder; signed division SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend.
REQ-018 For divide by zero, the unit SHALL return quotient = all ones and remainder = a, with unchanged latency.
REQ-019 For signed overflow (a = -2^(N-1), b = -1), the unit SHALL return quotient = a and remainder = 0.
REQ-020 In DONE, result SHALL stay stable until out_ready=1; on that edge the unit SHALL return to IDLE.
REQ-021 in_ready SHALL be 0 in DONE, so there is no same-cycle accept on drain; the next accept is possible one cycle later.
REQ-022 flush=1 in any state SHALL force IDLE on the next edge and discard any pending result; out_valid SHALL be 0 the following cycle.
REQ-023 flush=1 and in_valid=1 in the same IDLE cycle: flush SHALL win, and no operation is accepted.
REQ-024 In DONE, flush=1 and out_ready=1 in the same cycle: the unit SHALL go to IDLE, and the result counts as consumed.
REQ-025 In IDLE and BUSY, result SHALL read as 0.

Reset
REQ-026 Reset SHALL asynchronously force state=IDLE, the counter to 0, all operand and accumulator registers to 0, in_ready=1, out_valid=0 and result=0.
REQ-027 Reset asserted mid-BUSY SHALL abandon the operation; after deassertion, the first accept SHALL behave as after power-up.

Configuration
REQ-028 Macro MULDIV_SIGNED_EN SHALL control signed support.
REQ-029 With MULDIV_SIGNED_EN defined, op[2] SHALL select signed handling: operand sign fix-up before iteration, result negation after, and REQ-017 and REQ-019 apply.
REQ-030 Without MULDIV_SIGNED_EN, op[2] SHALL be ignored, all operations SHALL be unsigned, no sign fix-up logic SHALL be synthesized, and latency SHALL be unchanged.

Verification (N=32)
REQ-031 MUL a=0x0000_0007, b=0x0000_0006, op=000 -> out_valid exactly 33 cycles after accept, result=0x0000_002A.
REQ-032 MULH unsigned a=b=0xFFFF_FFFF, op=001 -> result=0xFFFF_FFFE; with MULDIV_SIGNED_EN, op=101 -> result=0x0000_0000.
REQ-033 DIV/REM signed a=0xFFFF_FFF9 (-7), b=2, op=110/111 -> quotient 0xFFFF_FFFD, remainder 0xFFFF_FFFF; DIV a=0x8000_0000, b=0xFFFF_FFFF signed -> quotient 0x8000_0000, remainder 0.
REQ-034 DIVU a=0x1234, b=0 -> quotient 0xFFFF_FFFF; REMU of the same operands -> remainder 0x0000_1234; latency 33 cycles for both.
REQ-035 Accept, then flush at BUSY cycle 10 -> IDLE next cycle, in_ready=1, no out_valid; a new op issued immediately completes correctly.
REQ-036 Hold out_ready=0 for 5 cycles in DONE -> result stable and in_ready=0 throughout; out_ready=1 -> IDLE next cycle; reset pulse mid-BUSY -> all outputs reset immediately.
